// File: rtl/food_pkg.sv
// Shared definitions for the money path: controller states, the
// denomination index type and the default coin values that the coin
// acceptor and the change dispenser must agree on.
package food_pkg;

    // Payout controller states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_REQ    = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Index of a coin denomination, 0 = smallest, 3 = largest
    typedef logic [1:0] denom_t;

    localparam int NUM_DENOM = 4;

    // Default coin values in units of the smallest coin, ascending
    localparam int DEF_VAL0 = 1;
    localparam int DEF_VAL1 = 2;
    localparam int DEF_VAL2 = 5;
    localparam int DEF_VAL3 = 10;

    localparam int DEF_INIT_STOCK  = 20;
    localparam int DEF_ACK_TIMEOUT = 255;

endpackage : food_pkg

// File: rtl/change_dispenser_if.sv
// Controller/hopper facing bundle of the change dispenser. The master
// side is the sale controller plus hopper; the slave side is the dispenser.
interface change_dispenser_if
    import food_pkg::*;
#(
    parameter int AMT_W = 10,
    parameter int CNT_W = 8
);
    // Payout request from the sale controller
    logic             start;
    logic [AMT_W-1:0] change_amt;
    // Hopper handshake
    logic             coin_req;
    denom_t           coin_sel;
    logic             coin_ack;
    // Stock refill
    logic             load_en;
    denom_t           load_sel;
    logic [CNT_W-1:0] load_cnt;
    // Status back to the controller
    logic             busy;
    logic             done;
    logic             short;
    logic             fault;
    logic [AMT_W-1:0] shortfall;
    logic [CNT_W-1:0] stock0;
    logic [CNT_W-1:0] stock1;
    logic [CNT_W-1:0] stock2;
    logic [CNT_W-1:0] stock3;

    modport master (
        output start, change_amt, coin_ack, load_en, load_sel, load_cnt,
        input  coin_req, coin_sel, busy, done, short, fault, shortfall,
               stock0, stock1, stock2, stock3
    );

    modport slave (
        input  start, change_amt, coin_ack, load_en, load_sel, load_cnt,
        output coin_req, coin_sel, busy, done, short, fault, shortfall,
               stock0, stock1, stock2, stock3
    );

endinterface : change_dispenser_if

// File: rtl/coin_stock.sv
// Four per-denomination coin stock counters. A refill adds coins and
// saturates at the counter maximum; a decrement removes one ejected coin
// and never wraps below zero. Refill and decrement are never requested in
// the same cycle by the controller, refill is given priority regardless.
module coin_stock
    import food_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int INIT_STOCK = DEF_INIT_STOCK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load_en,
    input  denom_t           i_load_sel,
    input  logic [CNT_W-1:0] i_load_cnt,
    input  logic             i_dec_en,
    input  denom_t           i_dec_sel,
    output logic [CNT_W-1:0] o_stock [NUM_DENOM],
    output logic [NUM_DENOM-1:0] o_nonzero
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DENOM; gi++) begin : g_cnt
            logic [CNT_W-1:0] r_cnt;
            logic [CNT_W:0]   w_sum;
            logic [CNT_W-1:0] w_sat;
            logic             w_hit_load;
            logic             w_hit_dec;

            // One extra bit catches the carry that signals saturation
            assign w_sum      = {1'b0, r_cnt} + {1'b0, i_load_cnt};
            assign w_sat      = w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
            assign w_hit_load = i_load_en && (i_load_sel == denom_t'(gi));
            assign w_hit_dec  = i_dec_en && (i_dec_sel == denom_t'(gi))
                                && (r_cnt != '0);

            // Stock counter: refill with saturation or remove one coin
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= CNT_W'(INIT_STOCK);
                end else if (w_hit_load) begin
                    r_cnt <= w_sat;
                end else if (w_hit_dec) begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
            end

            assign o_stock[gi]   = r_cnt;
            assign o_nonzero[gi] = (r_cnt != '0);
        end
    endgenerate

endmodule : coin_stock

// File: rtl/change_dispenser.sv
// Change dispenser: pays a requested amount one coin at a time through a
// req/ack hopper handshake, always picking the largest coin that fits the
// remaining amount and is in stock. Reports done, short-change (stock ran
// out) and fault (hopper did not answer) to the sale controller.
module change_dispenser
    import food_pkg::*;
#(
    parameter int AMT_W       = 10,
    parameter int CNT_W       = 8,
    parameter int VAL0        = DEF_VAL0,
    parameter int VAL1        = DEF_VAL1,
    parameter int VAL2        = DEF_VAL2,
    parameter int VAL3        = DEF_VAL3,
    parameter int INIT_STOCK  = DEF_INIT_STOCK,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst_n,
    change_dispenser_if.slave  bus
);

    // The counter runs 0..ACK_TIMEOUT-1; reaching the last value with no
    // ack ends the request, so coin_req is high exactly ACK_TIMEOUT cycles.
    localparam int TMO_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [AMT_W-1:0]   r_remaining;
    logic [AMT_W-1:0]   w_remaining_next;
    denom_t             r_coin_sel;
    denom_t             w_coin_sel_next;
    logic               r_short;
    logic               w_short_next;
    logic               r_fault;
    logic               w_fault_next;
    logic [AMT_W-1:0]   r_shortfall;
    logic [AMT_W-1:0]   w_shortfall_next;
    logic [TMO_W-1:0]   r_tmo;
    logic [TMO_W-1:0]   w_tmo_next;

    logic               w_load_en;
    logic               w_dec_en;
    logic [CNT_W-1:0]   w_stock [NUM_DENOM];
    logic [NUM_DENOM-1:0] w_nonzero;
    logic [NUM_DENOM-1:0] w_elig;
    logic               w_any_elig;
    denom_t             w_pick;
    logic [AMT_W-1:0]   w_val [NUM_DENOM];

    assign w_val[0] = AMT_W'(VAL0);
    assign w_val[1] = AMT_W'(VAL1);
    assign w_val[2] = AMT_W'(VAL2);
    assign w_val[3] = AMT_W'(VAL3);

    // A denomination is eligible if it fits the remaining amount and at
    // least one coin of it is in stock; this also prevents underflow.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DENOM; gi++) begin : g_elig
            assign w_elig[gi] = w_nonzero[gi] && (w_val[gi] <= r_remaining);
        end
    endgenerate

    assign w_any_elig = |w_elig;

    // Greedy pick: the highest eligible index wins (values are ascending)
    always_comb begin
        w_pick = '0;
        for (int i = 0; i < NUM_DENOM; i++) begin
            if (w_elig[i]) begin
                w_pick = denom_t'(i);
            end
        end
    end

    coin_stock #(
        .CNT_W      (CNT_W),
        .INIT_STOCK (INIT_STOCK)
    ) u_stock (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load_en  (w_load_en),
        .i_load_sel (bus.load_sel),
        .i_load_cnt (bus.load_cnt),
        .i_dec_en   (w_dec_en),
        .i_dec_sel  (r_coin_sel),
        .o_stock    (w_stock),
        .o_nonzero  (w_nonzero)
    );

    // Next-state and datapath update for the payout sequence
    always_comb begin
        w_state_next     = r_state;
        w_remaining_next = r_remaining;
        w_coin_sel_next  = r_coin_sel;
        w_short_next     = r_short;
        w_fault_next     = r_fault;
        w_shortfall_next = r_shortfall;
        w_tmo_next       = r_tmo;
        w_load_en        = 1'b0;
        w_dec_en         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // start wins over a simultaneous refill, which is dropped
                if (bus.start) begin
                    w_remaining_next = bus.change_amt;
                    w_short_next     = 1'b0;
                    w_fault_next     = 1'b0;
                    w_shortfall_next = '0;
                    w_state_next     = ST_SELECT;
                end else if (bus.load_en) begin
                    w_load_en = 1'b1;
                end
            end

            ST_SELECT: begin
                if (r_remaining == '0) begin
                    w_state_next = ST_DONE;
                end else if (w_any_elig) begin
                    w_coin_sel_next = w_pick;
                    w_tmo_next      = '0;
                    w_state_next    = ST_REQ;
                end else begin
                    w_shortfall_next = r_remaining;
                    w_short_next     = 1'b1;
                    w_state_next     = ST_DONE;
                end
            end

            ST_REQ: begin
                if (bus.coin_ack) begin
                    w_remaining_next = r_remaining - w_val[r_coin_sel];
                    w_dec_en         = 1'b1;
                    w_state_next     = ST_SELECT;
                end else if (r_tmo == TMO_LAST) begin
                    w_fault_next     = 1'b1;
                    w_shortfall_next = r_remaining;
                    w_state_next     = ST_DONE;
                end else begin
                    w_tmo_next = r_tmo + TMO_W'(1);
                end
            end

            ST_DONE: begin
                w_state_next = ST_IDLE;
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any payout in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_coin_sel  <= '0;
            r_short     <= 1'b0;
            r_fault     <= 1'b0;
            r_shortfall <= '0;
            r_tmo       <= '0;
        end else begin
            r_state     <= w_state_next;
            r_remaining <= w_remaining_next;
            r_coin_sel  <= w_coin_sel_next;
            r_short     <= w_short_next;
            r_fault     <= w_fault_next;
            r_shortfall <= w_shortfall_next;
            r_tmo       <= w_tmo_next;
        end
    end

    // coin_req decodes straight from state so reset drops it at once
    assign bus.coin_req  = (r_state == ST_REQ);
    assign bus.coin_sel  = r_coin_sel;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.done      = (r_state == ST_DONE);
    assign bus.short     = r_short;
    assign bus.fault     = r_fault;
    assign bus.shortfall = r_shortfall;
    assign bus.stock0    = w_stock[0];
    assign bus.stock1    = w_stock[1];
    assign bus.stock2    = w_stock[2];
    assign bus.stock3    = w_stock[3];

endmodule : change_dispenser

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed payouts from the test plan plus a
// randomized mix of refills and payouts, all scored against a
// transaction-level model of coin stock and greedy change making.
module tb_change_dispenser;

    localparam int AMT_W    = 10;
    localparam int CNT_W    = 8;
    localparam int ACK_TMO  = 255;
    localparam int INIT_STK = 20;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    int vals [4] = '{1, 2, 5, 10};

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    change_dispenser_if #(.AMT_W(AMT_W), .CNT_W(CNT_W)) bus ();

    change_dispenser #(
        .AMT_W       (AMT_W),
        .CNT_W       (CNT_W),
        .VAL0        (1),
        .VAL1        (2),
        .VAL2        (5),
        .VAL3        (10),
        .INIT_STOCK  (INIT_STK),
        .ACK_TIMEOUT (ACK_TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int m_stock [4];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int dut_stock(input int i);
        case (i)
            0:       return int'(bus.stock0);
            1:       return int'(bus.stock1);
            2:       return int'(bus.stock2);
            default: return int'(bus.stock3);
        endcase
    endfunction

    // Largest coin that fits and is in stock, -1 when none
    function automatic int pick(input int rem);
        int p = -1;
        for (int i = 0; i < 4; i++) begin
            if (vals[i] <= rem && m_stock[i] > 0) p = i;
        end
        return p;
    endfunction

    task automatic check_stocks(input string tag);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("%s_stock%0d", tag, i), dut_stock(i), m_stock[i]);
        end
    endtask

    task automatic refill(input int sel, input int cnt);
        @(negedge clk);
        bus.load_en  = 1'b1;
        bus.load_sel = 2'(sel);
        bus.load_cnt = 8'(cnt);
        @(negedge clk);
        bus.load_en = 1'b0;
        m_stock[sel] = (m_stock[sel] + cnt > CNT_MAX) ? CNT_MAX : m_stock[sel] + cnt;
        check_eq($sformatf("refill_stock%0d", sel), dut_stock(sel), m_stock[sel]);
        $display("refill sel=%0d cnt=%0d -> stock=%0d", sel, cnt, dut_stock(sel));
    endtask

    // One payout. stall_at: index of the coin the hopper never acks (-1 none).
    // poke: drive start/load_en while busy. load_too: load_en alongside start.
    task automatic pay(input int amt, input int stall_at, input bit poke, input bit load_too);
        int rem, sel, ncoin, waitn, req_cyc, e_fall;
        bit e_short, e_fault;
        @(negedge clk);
        bus.start      = 1'b1;
        bus.change_amt = AMT_W'(amt);
        if (load_too) begin
            bus.load_en  = 1'b1;
            bus.load_sel = 2'($urandom_range(0, 3));
            bus.load_cnt = 8'($urandom_range(1, 255));
        end
        @(negedge clk);
        bus.start   = 1'b0;
        bus.load_en = 1'b0;
        check_eq("busy_select", bus.busy, 1);
        check_eq("req_select", bus.coin_req, 0);
        rem = amt; ncoin = 0; e_short = 0; e_fault = 0; e_fall = 0;
        while (1) begin
            if (rem == 0) break;
            sel = pick(rem);
            if (sel < 0) begin
                e_short = 1;
                e_fall  = rem;
                break;
            end
            @(negedge clk);
            check_eq("coin_req", bus.coin_req, 1);
            check_eq("coin_sel", bus.coin_sel, sel);
            if (ncoin == stall_at) begin
                req_cyc = 0;
                while (bus.coin_req === 1'b1 && req_cyc < ACK_TMO + 8) begin
                    req_cyc++;
                    @(negedge clk);
                end
                check_eq("tmo_len", req_cyc, ACK_TMO);
                e_fault = 1;
                e_fall  = rem;
                break;
            end
            waitn = $urandom_range(0, 3);
            repeat (waitn) begin
                if (poke) begin
                    bus.start      = 1'b1;
                    bus.change_amt = 10'($urandom_range(0, 1023));
                    bus.load_en    = 1'b1;
                    bus.load_sel   = 2'($urandom_range(0, 3));
                    bus.load_cnt   = 8'($urandom_range(1, 255));
                end
                @(negedge clk);
                check_eq("req_hold", bus.coin_req, 1);
                check_eq("sel_hold", bus.coin_sel, sel);
            end
            bus.coin_ack = 1'b1;
            @(negedge clk);
            bus.coin_ack = 1'b0;
            bus.start    = 1'b0;
            bus.load_en  = 1'b0;
            m_stock[sel]--;
            rem -= vals[sel];
            ncoin++;
        end
        if (!e_fault) @(negedge clk);
        check_eq("done", bus.done, 1);
        check_eq("req_in_done", bus.coin_req, 0);
        check_eq("short", bus.short, 32'(e_short));
        check_eq("fault", bus.fault, 32'(e_fault));
        check_eq("shortfall", bus.shortfall, e_fall);
        @(negedge clk);
        check_eq("done_pulse", bus.done, 0);
        check_eq("busy_idle", bus.busy, 0);
        check_eq("short_held", bus.short, 32'(e_short));
        check_stocks("pay");
        $display("pay amt=%0d coins=%0d short=%0d fault=%0d shortfall=%0d",
                 amt, ncoin, e_short, e_fault, e_fall);
    endtask

    task automatic reset_mid_payout();
        int exp_req;
        exp_req = (pick(37) >= 0) ? 1 : 0;
        @(negedge clk);
        bus.start      = 1'b1;
        bus.change_amt = 10'd37;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check_eq("rst_pre_req", bus.coin_req, exp_req);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) m_stock[i] = INIT_STK;
        check_eq("rst_req_drop", bus.coin_req, 0);
        check_eq("rst_busy", bus.busy, 0);
        check_stocks("rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_eq("rst_no_done", bus.done, 0);
            @(negedge clk);
        end
        $display("reset during payout of 37");
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r;
        bus.start      = 1'b0;
        bus.change_amt = '0;
        bus.coin_ack   = 1'b0;
        bus.load_en    = 1'b0;
        bus.load_sel   = '0;
        bus.load_cnt   = '0;
        for (int i = 0; i < 4; i++) m_stock[i] = INIT_STK;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_req", bus.coin_req, 0);
        check_eq("reset_busy", bus.busy, 0);
        check_eq("reset_done", bus.done, 0);
        check_eq("reset_short", bus.short, 0);
        check_eq("reset_fault", bus.fault, 0);
        check_eq("reset_shortfall", bus.shortfall, 0);
        check_eq("reset_sel", bus.coin_sel, 0);
        check_stocks("reset");
        rst_n = 1'b1;

        pay(18, -1, 1'b0, 1'b0);      // 10,5,2,1
        pay(0, -1, 1'b0, 1'b0);       // done two cycles after start
        pay(7, 0, 1'b0, 1'b0);        // hopper never acks
        refill(2, 4);
        pay(20, -1, 1'b1, 1'b0);      // start/load pokes while busy
        pay(30, -1, 1'b0, 1'b1);      // refill dropped under start
        pay(1000, -1, 1'b0, 1'b0);    // drains every stock, short
        refill(2, 1);
        pay(7, -1, 1'b0, 1'b0);       // one five, then short by 2
        refill(0, 200);
        refill(0, 200);               // saturates
        refill(1, 30);
        refill(3, 12);

        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(0, 9);
            if (r < 3) begin
                refill($urandom_range(0, 3), $urandom_range(0, 255));
            end else begin
                pay($urandom_range(0, 150),
                    ($urandom_range(0, 9) == 0) ? $urandom_range(0, 2) : -1,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end

        reset_mid_payout();
        pay(18, -1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_change_dispenser

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Pays out customer change after a sale, one coin at a time, to the coin hopper. It is the payout end of the money path; the coin acceptor is the collection end.
- The sale controller hands it a change amount with a start pulse. It picks coins greedily, largest first, from four denominations with on-board stock counters.
- It drives a req/ack handshake to the hopper and reports done, short-change and fault status back to the controller.

Parameters:
- AMT_W, 10, width of amounts (units of the smallest coin)
- CNT_W, 8, width of each stock counter
- VAL0, 1, value of denomination 0 (smallest)
- VAL1, 2, value of denomination 1
- VAL2, 5, value of denomination 2
- VAL3, 10, value of denomination 3 (largest)
- INIT_STOCK, 20, stock of every denomination after reset
- ACK_TIMEOUT, 255, max cycles coin_req may stay high without coin_ack

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to pay change_amt; honoured only in IDLE
- change_amt  in  AMT_W  amount to pay, sampled with start
- coin_ack  in  1  hopper has released the requested coin; sampled only while coin_req=1
- load_en  in  1  refill strobe; honoured only in IDLE
- load_sel  in  2  denomination to refill
- load_cnt  in  CNT_W  coins added to the stock of load_sel
- coin_req  out  1  request to eject one coin
- coin_sel  out  2  denomination requested; stable while coin_req=1
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at the end of a payout
- short  out  1  last payout could not be completed from stock; held until next start
- fault  out  1  last payout aborted on ack timeout; held until next start
- shortfall  out  AMT_W  amount left unpaid by last payout; held until next start
- stock0..stock3  out  CNT_W each  current stock per denomination

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; coin_req, done, short, fault, busy = 0.
  - coin_sel=0, shortfall=0, remaining=0, every stock = INIT_STOCK.
  - coin_req drops immediately, even in the middle of a payout. The payout is lost and no done pulse follows.
- IDLE:
  - start=1: latch change_amt into remaining; clear short, fault and shortfall; go to SELECT.
  - load_en=1 (without start): stock[load_sel] += load_cnt, saturating at 2^CNT_W-1.
  - start and load_en in the same cycle: start wins and the refill is dropped.
- SELECT (one cycle):
  - remaining=0: go to DONE.
  - Otherwise choose the highest i with VALi <= remaining and stock[i] > 0. Register it to coin_sel, set coin_req=1, clear the timeout counter, go to REQ.
  - No eligible coin: shortfall=remaining, short=1, go to DONE.
- REQ:
  - coin_req=1 and coin_sel held.
  - coin_ack=1:
    - on the next edge, coin_req=0, remaining -= VAL[coin_sel], stock[coin_sel] -= 1;
    - go to SELECT.
    - An ack in the very first REQ cycle is valid.
  - Timeout counter increments each REQ cycle without ack. When it reaches ACK_TIMEOUT:
    - coin_req=0, fault=1, shortfall=remaining;
    - go to DONE with stock unchanged.
- DONE (one cycle): done=1, go to IDLE.
- Ignored inputs:
  - start is ignored whenever busy=1.
  - load_en is ignored whenever busy=1.
  - coin_ack outside REQ is ignored.
- Latency and timing:
  - start at edge N gives SELECT at N+1 and coin_req high from N+2.
  - Each coin costs 1 SELECT cycle plus the REQ cycles up to and including the ack.
  - change_amt=0 gives done in cycle N+2 and no coin_req.
- Arithmetic:
  - Comparisons and subtraction are unsigned, AMT_W wide; remaining never underflows because of the SELECT check.
  - Stock decrements only on ack, so stock cannot go below 0.
- Greedy selection is final. Short is reported even where a different mix of coins could have paid exactly.

Decomposition:
- Shared package food_pkg:
  - state enum (IDLE, SELECT, REQ, DONE);
  - the 2-bit denomination index type;
  - the default coin value constants, shared with the coin acceptor.
- One sub-module: coin_stock. It holds the four saturating counters, refill and decrement ports, and exposes stock values plus a per-denomination nonzero flag.

Test Plan:
- Full stock, start with change_amt=18, ack one cycle after each req → coin_sel sequence 3,2,1,0; done pulse; short=0; stock3=19, stock2=19, stock1=19, stock0=19.
- change_amt=0 → done high exactly 2 cycles after start; coin_req never high; stock unchanged.
- Load stock3=0 via reset and no refill (INIT_STOCK=0 build), refill stock2 with 4, change 20 → four coins of sel=2; done; short=0; stock2=0.
- stock2=1, all others 0, change 7 → one coin sel=2, then done with short=1 and shortfall=2.
- Hopper never acks → coin_req high for ACK_TIMEOUT cycles, then fault=1, done pulse, shortfall=change_amt; stock unchanged.
- Stimulus during and around a payout:
  - start pulse while busy → ignored;
  - load_en while busy → ignored;
  - rst_n low during REQ → coin_req=0 in the same cycle, stocks return to INIT_STOCK, no done pulse.
